core_boot_ctrl: RTL and testbench
=================================

CORE_BOOT_CTRL -- requirements
Module: core_boot_ctrl

Interface
REQ-001 SHALL have parameter DATA_WORDS, default 1024, meaning the number of data-memory words loaded.
REQ-002 SHALL have parameter INSTR_WORDS, default 1024, meaning the number of INSTR packets sent.
REQ-003 SHALL have parameter REG_WORDS, default 2**rs_imm_size_p, meaning the number of REG packets sent.
REQ-004 SHALL have parameters START_PC (default 0), BAR_MASK (default 32'h2), BAR_ADD (default 10'd24) and CORE_ID (default 10'b0000000001).
REQ-005 SHALL have a single clock `clk` (input, 1 bit); `reset` (input, 1 bit) is synchronous and active-high.
REQ-006 SHALL have `start_i` (input, 1 bit): a pulse that begins a boot sequence.
REQ-007 SHALL have `busy_o` and `done_o` (outputs, 1 bit each): boot in progress, and core released respectively.
REQ-008 SHALL have `rom_sel_o` (output, 2 bits; 0 = data, 1 = instr, 2 = reg) and `rom_addr_o` (output, 10 bits): boot image read address.
REQ-009 SHALL have `rom_data_i` (input, 40 bits): boot image word, valid exactly one cycle after its address.
REQ-010 SHALL have `to_mem_o` (output, mem_in_s), `data_mem_addr_o` (output, 32 bits) and `from_mem_i` (input, mem_out_s).
REQ-011 SHALL have `core_owns_mem_o` (output, 1 bit): the data-memory port mux select (1 = core, 0 = this block).
REQ-012 SHALL have `net_packet_o` (output, net_packet_s): packet driven to the core's network input.

Function
REQ-013 SHALL implement states IDLE, LD_DATA, DRAIN, LD_INSTR, LD_REG, SET_PC, SET_BAR, RUN.
REQ-014 SHALL move IDLE->LD_DATA when start_i=1; start_i SHALL be ignored in every other state except RUN.
REQ-015 SHALL, in LD_DATA, present a write for word i: valid=1, wen=1, byte_not_word=0, yumi=1, addr=i*4, write_data=rom_data_i[31:0].
REQ-016 SHALL hold each LD_DATA request stable until from_mem_i.yumi=1 is sampled at a clk edge, then advance i (0..DATA_WORDS-1).
REQ-017 SHALL go LD_DATA->DRAIN after the last word is accepted; DRAIN lasts 1 cycle with valid=0 and yumi=0.
REQ-018 SHALL go DRAIN->LD_INSTR and, one cycle later, emit exactly INSTR_WORDS consecutive INSTR packets, one per cycle.
REQ-019 SHALL build each INSTR packet as net_data={16'b0, rom_data_i[15:0]}, net_add=i, ID=CORE_ID.
REQ-020 SHALL go LD_INSTR->LD_REG and emit REG_WORDS consecutive REG packets with net_data=rom_data_i[31:0] and net_add=rom_data_i[37:32].
REQ-021 SHALL then spend one cycle in SET_PC (net_op PC, net_data=START_PC, net_add=0) followed by one cycle in SET_BAR (net_op BAR, net_data=BAR_MASK, net_add=BAR_ADD).
REQ-022 SHALL, in RUN, drive net_op NULL, core_owns_mem_o=1, done_o=1 and busy_o=0.
REQ-023 SHALL drive busy_o=1 in LD_DATA through SET_BAR, and net_op NULL in every state except LD_INSTR, LD_REG, SET_PC and SET_BAR.
REQ-024 SHALL, on start_i=1 in RUN, clear core_owns_mem_o and done_o on the next cycle and re-enter LD_DATA.
REQ-025 SHALL use a word counter that does not wrap: the terminal count is DATA_WORDS-1, INSTR_WORDS-1 or REG_WORDS-1 respectively, and the counter clears on each state change.
REQ-026 SHALL issue rom_addr_o one cycle ahead of its use, including the first address of each phase being issued in the preceding state.
REQ-027 SHALL drive core_owns_mem_o=0 in every state except RUN.

Reset
REQ-028 SHALL, while reset=1 is sampled, enter IDLE, clear counters, and drive busy_o=0, done_o=0, core_owns_mem_o=0, to_mem_o all-zero, data_mem_addr_o=0, rom_addr_o=0, rom_sel_o=0, and net_packet_o=0 (net_op NULL).
REQ-029 SHALL, on reset mid-sequence, abort with no further memory writes or packets; a new start_i is then required.

Structure
REQ-030 SHALL take net_packet_s, mem_in_s, mem_out_s and the net_op encodings from the shared definitions package, and SHALL add boot_state_e there.
REQ-031 SHALL contain one sub-module, boot_addr_ctr (loadable counter with terminal-count flag); all else is inline.

Verification (DATA_WORDS=4, INSTR_WORDS=3, REG_WORDS=2, START_PC=5)
REQ-032 Reset then idle: after reset, all outputs are zero/NULL, and with no start_i, busy_o stays 0 for 20 cycles.
REQ-033 Full boot with memory yumi always 1: exactly 4 writes to addr 0,4,8,12, then 3 INSTR, 2 REG, PC=5, BAR=2; done_o=1 exactly 14 cycles after start_i.
REQ-034 Memory stall: yumi withheld 3 cycles on word 2; addr=8 and write_data are held stable throughout, with no duplicate or skipped writes.
REQ-035 Reset asserted during LD_INSTR at packet 1: the next cycle shows net_op NULL and IDLE, and no REG/PC/BAR packets follow.
REQ-036 start_i pulsed in LD_REG is ignored; start_i pulsed in RUN drops core_owns_mem_o to 0 and repeats the full sequence.
REQ-037 REG packet mapping: rom word 40'h05_DEADBEEF yields net_add=6'd5 and net_data=32'hDEADBEEF.

Source files
------------

// File: rtl/core_boot_ctrl_pkg.sv
// Shared definitions for the boot controller: memory/network packet types,
// network opcodes, boot-image selectors and the boot sequencer states.
package core_boot_ctrl_pkg;

    localparam int rs_imm_size_p = 6;
    localparam int ADDR_W        = 10;

    typedef enum logic [2:0] {
        NET_OP_NULL  = 3'd0,
        NET_OP_INSTR = 3'd1,
        NET_OP_REG   = 3'd2,
        NET_OP_PC    = 3'd3,
        NET_OP_BAR   = 3'd4
    } net_op_e;

    typedef struct packed {
        net_op_e     net_op;
        logic [9:0]  id;
        logic [9:0]  net_add;
        logic [31:0] net_data;
    } net_packet_s;

    typedef struct packed {
        logic        valid;
        logic        wen;
        logic        byte_not_word;
        logic        yumi;
        logic [31:0] write_data;
    } mem_in_s;

    typedef struct packed {
        logic        valid;
        logic        yumi;
        logic [31:0] read_data;
    } mem_out_s;

    typedef enum logic [1:0] {
        ROM_DATA  = 2'd0,
        ROM_INSTR = 2'd1,
        ROM_REG   = 2'd2
    } rom_sel_e;

    typedef enum logic [2:0] {
        IDLE,
        LD_DATA,
        DRAIN,
        LD_INSTR,
        LD_REG,
        SET_PC,
        SET_BAR,
        RUN
    } boot_state_e;

endpackage

// File: rtl/core_boot_ctrl_addr_ctr.sv
// Non-wrapping word counter: counts up to a loadable terminal value, holds
// there, and flags the terminal count.
module boot_addr_ctr
    import core_boot_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              en,
    input  logic [ADDR_W-1:0] last,
    output logic [ADDR_W-1:0] count,
    output logic              tc
);

    assign tc = (count == last);

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (en && !tc) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/core_boot_ctrl.sv
// Boot sequencer: copies the data image into data memory, streams INSTR and
// REG packets to the core, sets PC and barrier mask, then releases the core.
module core_boot_ctrl
    import core_boot_ctrl_pkg::*;
#(
    parameter int          DATA_WORDS  = 1024,
    parameter int          INSTR_WORDS = 1024,
    parameter int          REG_WORDS   = 2**rs_imm_size_p,
    parameter logic [31:0] START_PC    = 32'd0,
    parameter logic [31:0] BAR_MASK    = 32'h2,
    parameter logic [9:0]  BAR_ADD     = 10'd24,
    parameter logic [9:0]  CORE_ID     = 10'b0000000001
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [1:0]  rom_sel_o,
    output logic [9:0]  rom_addr_o,
    input  logic [39:0] rom_data_i,
    output mem_in_s     to_mem_o,
    output logic [31:0] data_mem_addr_o,
    input  mem_out_s    from_mem_i,
    output logic        core_owns_mem_o,
    output net_packet_s net_packet_o
);

    localparam logic [ADDR_W-1:0] DATA_LAST  = ADDR_W'(DATA_WORDS - 1);
    localparam logic [ADDR_W-1:0] INSTR_LAST = ADDR_W'(INSTR_WORDS - 1);
    localparam logic [ADDR_W-1:0] REG_LAST   = ADDR_W'(REG_WORDS - 1);

    boot_state_e       state_q, state_n;
    logic              instr_armed_q;
    logic [ADDR_W-1:0] cnt, cnt_last, cnt_inc;
    logic              cnt_tc, cnt_en, cnt_clear;
    rom_sel_e          rom_sel;
    logic              unused_inputs;

    assign unused_inputs = ^{rom_data_i[39:38], from_mem_i.valid, from_mem_i.read_data};
    assign cnt_inc       = cnt + 1'b1;
    assign cnt_clear     = (state_n != state_q);

    always_comb begin
        case (state_q)
            LD_DATA:  cnt_last = DATA_LAST;
            LD_INSTR: cnt_last = INSTR_LAST;
            LD_REG:   cnt_last = REG_LAST;
            default:  cnt_last = '0;
        endcase
    end

    boot_addr_ctr u_ctr (
        .clk   (clk),
        .reset (reset),
        .clear (cnt_clear),
        .en    (cnt_en),
        .last  (cnt_last),
        .count (cnt),
        .tc    (cnt_tc)
    );

    // The first LD_INSTR cycle only waits for instruction word 0 to arrive.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            instr_armed_q <= 1'b0;
        end else begin
            state_q       <= state_n;
            instr_armed_q <= (state_q == LD_INSTR);
        end
    end

    // NOTE: every output of this block gets a default first, so no path
    // through the case statement can leave a latch behind.
    always_comb begin
        state_n         = state_q;
        cnt_en          = 1'b0;
        busy_o          = 1'b0;
        done_o          = 1'b0;
        core_owns_mem_o = 1'b0;
        rom_sel         = ROM_DATA;
        rom_addr_o      = '0;
        to_mem_o        = '0;
        data_mem_addr_o = '0;
        net_packet_o    = '0;

        case (state_q)
            IDLE: begin
                if (start_i) state_n = LD_DATA;
            end
            LD_DATA: begin
                busy_o                 = 1'b1;
                to_mem_o.valid         = 1'b1;
                to_mem_o.wen           = 1'b1;
                to_mem_o.byte_not_word = 1'b0;
                to_mem_o.yumi          = 1'b1;
                to_mem_o.write_data    = rom_data_i[31:0];
                data_mem_addr_o        = {{(32-ADDR_W-2){1'b0}}, cnt, 2'b00};
                cnt_en                 = from_mem_i.yumi;
                // Hold the ROM address while stalled so the word stays valid.
                if (!from_mem_i.yumi) begin
                    rom_addr_o = cnt;
                end else if (cnt_tc) begin
                    state_n = DRAIN;
                    rom_sel = ROM_INSTR;
                end else begin
                    rom_addr_o = cnt_inc;
                end
            end
            DRAIN: begin
                busy_o  = 1'b1;
                rom_sel = ROM_INSTR;
                state_n = LD_INSTR;
            end
            LD_INSTR: begin
                busy_o  = 1'b1;
                rom_sel = ROM_INSTR;
                if (instr_armed_q) begin
                    cnt_en                = 1'b1;
                    net_packet_o.net_op   = NET_OP_INSTR;
                    net_packet_o.id       = CORE_ID;
                    net_packet_o.net_add  = cnt;
                    net_packet_o.net_data = {16'b0, rom_data_i[15:0]};
                    if (cnt_tc) begin
                        state_n = LD_REG;
                        rom_sel = ROM_REG;
                    end else begin
                        rom_addr_o = cnt_inc;
                    end
                end
            end
            LD_REG: begin
                busy_o                = 1'b1;
                cnt_en                = 1'b1;
                net_packet_o.net_op   = NET_OP_REG;
                net_packet_o.id       = CORE_ID;
                net_packet_o.net_add  = {{(ADDR_W-rs_imm_size_p){1'b0}},
                                         rom_data_i[32 +: rs_imm_size_p]};
                net_packet_o.net_data = rom_data_i[31:0];
                if (cnt_tc) begin
                    state_n = SET_PC;
                end else begin
                    rom_sel    = ROM_REG;
                    rom_addr_o = cnt_inc;
                end
            end
            SET_PC: begin
                busy_o                = 1'b1;
                net_packet_o.net_op   = NET_OP_PC;
                net_packet_o.id       = CORE_ID;
                net_packet_o.net_data = START_PC;
                state_n               = SET_BAR;
            end
            SET_BAR: begin
                busy_o                = 1'b1;
                net_packet_o.net_op   = NET_OP_BAR;
                net_packet_o.id       = CORE_ID;
                net_packet_o.net_add  = BAR_ADD;
                net_packet_o.net_data = BAR_MASK;
                state_n               = RUN;
            end
            RUN: begin
                done_o          = 1'b1;
                core_owns_mem_o = 1'b1;
                if (start_i) state_n = LD_DATA;
            end
            default: state_n = IDLE;
        endcase

        // A cycle with reset asserted must not leak a write or a packet.
        if (reset) begin
            busy_o          = 1'b0;
            done_o          = 1'b0;
            core_owns_mem_o = 1'b0;
            rom_sel         = ROM_DATA;
            rom_addr_o      = '0;
            to_mem_o        = '0;
            data_mem_addr_o = '0;
            net_packet_o    = '0;
        end
    end

    assign rom_sel_o = rom_sel;

endmodule

// File: tb/tb_core_boot_ctrl.sv
// Self-checking bench for core_boot_ctrl: cycle table for a full boot plus
// hand sequences for stall, restart and mid-boot reset; scoreboarded events.
module tb_core_boot_ctrl;
    import core_boot_ctrl_pkg::*;

    localparam int          DATA_WORDS  = 4;
    localparam int          INSTR_WORDS = 3;
    localparam int          REG_WORDS   = 2;
    localparam logic [31:0] START_PC    = 32'd5;
    localparam logic [31:0] BAR_MASK    = 32'h2;
    localparam logic [9:0]  BAR_ADD     = 10'd24;
    localparam logic [9:0]  CORE_ID     = 10'd1;

    logic        clk = 1'b0;
    logic        reset, start_i, yumi;
    logic        busy_o, done_o, core_owns_mem_o;
    logic [1:0]  rom_sel_o;
    logic [9:0]  rom_addr_o;
    logic [39:0] rom_data_i;
    mem_in_s     to_mem_o;
    logic [31:0] data_mem_addr_o;
    mem_out_s    from_mem_i;
    net_packet_s net_packet_o;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic        is_pkt;
        logic [2:0]  op;
        logic [31:0] addr;
        logic [31:0] data;
    } exp_t;
    exp_t exp_q[$];

    typedef struct {
        logic       start;
        logic       yumi;
        logic       valid;
        logic       busy;
        logic       done;
        logic       owns;
        logic [2:0] op;
        logic [1:0] sel;
        logic [9:0] addr;
    } vec_t;
    vec_t vecs[16];

    logic [39:0] rom_d[DATA_WORDS];
    logic [39:0] rom_i[INSTR_WORDS];
    logic [39:0] rom_r[REG_WORDS];

    always #5 clk = ~clk;

    assign from_mem_i = '{valid: 1'b0, yumi: yumi, read_data: 32'h0};

    core_boot_ctrl #(
        .DATA_WORDS  (DATA_WORDS),
        .INSTR_WORDS (INSTR_WORDS),
        .REG_WORDS   (REG_WORDS),
        .START_PC    (START_PC),
        .BAR_MASK    (BAR_MASK),
        .BAR_ADD     (BAR_ADD),
        .CORE_ID     (CORE_ID)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .start_i         (start_i),
        .busy_o          (busy_o),
        .done_o          (done_o),
        .rom_sel_o       (rom_sel_o),
        .rom_addr_o      (rom_addr_o),
        .rom_data_i      (rom_data_i),
        .to_mem_o        (to_mem_o),
        .data_mem_addr_o (data_mem_addr_o),
        .from_mem_i      (from_mem_i),
        .core_owns_mem_o (core_owns_mem_o),
        .net_packet_o    (net_packet_o)
    );

    function automatic logic [39:0] rom_lookup(input logic [1:0] sel, input logic [9:0] a);
        int idx;
        idx = int'(a);
        case (sel)
            2'd0:    return (idx < DATA_WORDS)  ? rom_d[idx] : 40'h0;
            2'd1:    return (idx < INSTR_WORDS) ? rom_i[idx] : 40'h0;
            2'd2:    return (idx < REG_WORDS)   ? rom_r[idx] : 40'h0;
            default: return 40'h0;
        endcase
    endfunction

    // Boot image ROM with one cycle of read latency.
    always @(posedge clk) rom_data_i <= rom_lookup(rom_sel_o, rom_addr_o);

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic take_event(input logic is_pkt, input logic [2:0] op,
                              input logic [31:0] addr, input logic [31:0] data);
        exp_t e;
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_event: pkt=%0d op=%0d addr=0x%0h data=0x%0h expected none",
                     is_pkt, op, addr, data);
        end else begin
            e = exp_q.pop_front();
            check("ev_kind", is_pkt, e.is_pkt);
            check("ev_op",   op,     e.op);
            check("ev_addr", addr,   e.addr);
            check("ev_data", data,   e.data);
        end
    endtask

    task automatic push_boot();
        for (int i = 0; i < DATA_WORDS; i++)
            exp_q.push_back('{1'b0, NET_OP_NULL, 32'(i * 4), rom_d[i][31:0]});
        for (int i = 0; i < INSTR_WORDS; i++)
            exp_q.push_back('{1'b1, NET_OP_INSTR, 32'(i), {16'h0, rom_i[i][15:0]}});
        for (int i = 0; i < REG_WORDS; i++)
            exp_q.push_back('{1'b1, NET_OP_REG, {26'h0, rom_r[i][37:32]}, rom_r[i][31:0]});
        exp_q.push_back('{1'b1, NET_OP_PC, 32'h0, START_PC});
        exp_q.push_back('{1'b1, NET_OP_BAR, {22'h0, BAR_ADD}, BAR_MASK});
    endtask

    // Monitor: every accepted write and every non-NULL packet is scoreboarded.
    always @(negedge clk) begin
        if (to_mem_o.valid && from_mem_i.yumi) begin
            check("wr_ctl", {to_mem_o.wen, to_mem_o.byte_not_word, to_mem_o.yumi}, 3'b101);
            take_event(1'b0, NET_OP_NULL, data_mem_addr_o, to_mem_o.write_data);
        end
        if (net_packet_o.net_op != NET_OP_NULL) begin
            check("pkt_id", net_packet_o.id, CORE_ID);
            take_event(1'b1, net_packet_o.net_op, {22'h0, net_packet_o.net_add},
                       net_packet_o.net_data);
        end
    end

    task automatic step(input logic s, input logic y, input logic r);
        @(posedge clk);
        #1;
        start_i = s;
        yumi    = y;
        reset   = r;
        @(negedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic s, input logic v, input logic b, input logic d,
                                input logic o, input logic [2:0] op, input logic [1:0] sel,
                                input logic [9:0] a);
        vec_t t;
        t = '{start: s, yumi: 1'b1, valid: v, busy: b, done: d, owns: o, op: op, sel: sel, addr: a};
        return t;
    endfunction

    initial begin
        int busy_seen;
        int n;

        for (int i = 0; i < DATA_WORDS; i++) rom_d[i] = {8'h77, 32'hA000_0000 + 32'(i) * 32'h111};
        for (int i = 0; i < INSTR_WORDS; i++) rom_i[i] = {8'hC3, 16'h5A5A, 16'h1000 + 16'(i)};
        rom_r[0]   = 40'h05_DEADBEEF;
        rom_r[1]   = 40'hC2_12345678;
        rom_data_i = 40'h0;
        start_i    = 1'b0;
        yumi       = 1'b1;
        reset      = 1'b1;

        // Expected cycle-by-cycle view of a full boot started from IDLE.
        vecs[0]  = mk(1, 0, 0, 0, 0, NET_OP_NULL,  2'd0, 10'd0);
        vecs[1]  = mk(0, 1, 1, 0, 0, NET_OP_NULL,  2'd0, 10'd1);
        vecs[2]  = mk(0, 1, 1, 0, 0, NET_OP_NULL,  2'd0, 10'd2);
        vecs[3]  = mk(0, 1, 1, 0, 0, NET_OP_NULL,  2'd0, 10'd3);
        vecs[4]  = mk(0, 1, 1, 0, 0, NET_OP_NULL,  2'd1, 10'd0);
        vecs[5]  = mk(0, 0, 1, 0, 0, NET_OP_NULL,  2'd1, 10'd0);
        vecs[6]  = mk(0, 0, 1, 0, 0, NET_OP_NULL,  2'd1, 10'd0);
        vecs[7]  = mk(0, 0, 1, 0, 0, NET_OP_INSTR, 2'd1, 10'd1);
        vecs[8]  = mk(0, 0, 1, 0, 0, NET_OP_INSTR, 2'd1, 10'd2);
        vecs[9]  = mk(0, 0, 1, 0, 0, NET_OP_INSTR, 2'd2, 10'd0);
        vecs[10] = mk(0, 0, 1, 0, 0, NET_OP_REG,   2'd2, 10'd1);
        vecs[11] = mk(0, 0, 1, 0, 0, NET_OP_REG,   2'd0, 10'd0);
        vecs[12] = mk(0, 0, 1, 0, 0, NET_OP_PC,    2'd0, 10'd0);
        vecs[13] = mk(0, 0, 1, 0, 0, NET_OP_BAR,   2'd0, 10'd0);
        vecs[14] = mk(0, 0, 0, 1, 1, NET_OP_NULL,  2'd0, 10'd0);
        vecs[15] = mk(0, 0, 0, 1, 1, NET_OP_NULL,  2'd0, 10'd0);

        // Reset state, then an idle stretch with no start.
        step(0, 1, 1);
        step(0, 1, 1);
        check("rst_busy",     busy_o,          1'b0);
        check("rst_done",     done_o,          1'b0);
        check("rst_owns",     core_owns_mem_o, 1'b0);
        check("rst_to_mem",   to_mem_o,        '0);
        check("rst_mem_addr", data_mem_addr_o, 32'h0);
        check("rst_rom_addr", rom_addr_o,      10'h0);
        check("rst_rom_sel",  rom_sel_o,       2'd0);
        check("rst_packet",   net_packet_o,    '0);
        busy_seen = 0;
        for (int i = 0; i < 20; i++) begin
            step(0, 1, 0);
            if (busy_o) busy_seen++;
        end
        check("idle_busy_cycles", busy_seen, 0);

        // Full boot with yumi always high.
        for (int v = 0; v < 16; v++) begin
            if (vecs[v].start) push_boot();
            step(vecs[v].start, vecs[v].yumi, 1'b0);
            check($sformatf("v%0d_valid", v),    to_mem_o.valid,      vecs[v].valid);
            check($sformatf("v%0d_busy", v),     busy_o,              vecs[v].busy);
            check($sformatf("v%0d_done", v),     done_o,              vecs[v].done);
            check($sformatf("v%0d_owns", v),     core_owns_mem_o,     vecs[v].owns);
            check($sformatf("v%0d_op", v),       net_packet_o.net_op, vecs[v].op);
            check($sformatf("v%0d_rom_sel", v),  rom_sel_o,           vecs[v].sel);
            check($sformatf("v%0d_rom_addr", v), rom_addr_o,          vecs[v].addr);
        end
        check("boot_q_empty", exp_q.size(), 0);

        // Restart from RUN, stall word 2 for 3 cycles, ignored start in LD_REG.
        push_boot();
        step(1, 1, 0);
        check("restart_run_done", done_o, 1'b1);
        step(0, 1, 0);
        check("restart_owns", core_owns_mem_o, 1'b0);
        check("restart_done", done_o,          1'b0);
        check("restart_busy", busy_o,          1'b1);
        step(0, 1, 0);
        for (int k = 0; k < 3; k++) begin
            step(0, 0, 0);
            check($sformatf("stall%0d_valid", k),    to_mem_o.valid,      1'b1);
            check($sformatf("stall%0d_addr", k),     data_mem_addr_o,     32'd8);
            check($sformatf("stall%0d_data", k),     to_mem_o.write_data, rom_d[2][31:0]);
            check($sformatf("stall%0d_rom_addr", k), rom_addr_o,          10'd2);
        end
        for (int k = 0; k < 7; k++) step(0, 1, 0);
        step(1, 1, 0);
        check("ldreg_start_op", net_packet_o.net_op, NET_OP_REG);
        n = 13;
        do begin
            step(0, 1, 0);
            n++;
        end while (!done_o && n < 60);
        check("stall_done_cycle", n, 17);
        check("stall_q_empty", exp_q.size(), 0);

        // Reset while INSTR packet 1 would be on the network.
        push_boot();
        step(1, 1, 0);
        for (int k = 0; k < 7; k++) step(0, 1, 0);
        check("pre_rst_op",  net_packet_o.net_op,  NET_OP_INSTR);
        check("pre_rst_add", net_packet_o.net_add, 10'd0);
        step(0, 1, 1);
        check("rst_mid_op",    net_packet_o.net_op, NET_OP_NULL);
        check("rst_mid_valid", to_mem_o.valid,      1'b0);
        check("rst_mid_q_left", exp_q.size(), 6);
        exp_q.delete();
        step(0, 1, 0);
        check("post_rst_busy",    busy_o,              1'b0);
        check("post_rst_op",      net_packet_o.net_op, NET_OP_NULL);
        check("post_rst_owns",    core_owns_mem_o,     1'b0);
        check("post_rst_done",    done_o,              1'b0);
        check("post_rst_rom_sel", rom_sel_o,           2'd0);
        busy_seen = 0;
        for (int i = 0; i < 20; i++) begin
            step(0, 1, 0);
            if (busy_o || net_packet_o.net_op != NET_OP_NULL) busy_seen++;
        end
        check("post_rst_idle_cycles", busy_seen, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
